// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory bus between the memory-access stage and the data memory.
//   master (stage side) : drives dm_address, dm_data_in, dm_access_size, dm_rw, dm_enable;
//                         samples dm_busy, dm_data_out.
//   slave  (memory side): the mirror image.
interface mem_stage_if;
    logic [31:0] dm_address;
    logic [31:0] dm_data_in;
    logic [1:0]  dm_access_size;
    logic        dm_rw;
    logic        dm_enable;
    logic        dm_busy;
    logic [31:0] dm_data_out;

    modport master (
        output dm_address, dm_data_in, dm_access_size, dm_rw, dm_enable,
        input  dm_busy, dm_data_out
    );

    modport slave (
        input  dm_address, dm_data_in, dm_access_size, dm_rw, dm_enable,
        output dm_busy, dm_data_out
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage MIPS pipeline (between X/M and M/W).
// Ports:
//   clock, reset_n         pipeline clock, asynchronous active-low reset
//   valid_in, insn_in,     X/M contents: valid flag, instruction, ALU result / address,
//   addr_in, store_data_in rB store value, destination register and write enable
//   rd_in, rwe_in
//   wb_data/wb_rd/wb_rwe   writeback result for the W->M store-data bypass
//   dm                     data-memory bus (enable/rw/busy handshake)
//   stall_out              freezes F/D, D/X and X/M while an access is outstanding
//   misaligned             one-cycle pulse for an unaligned LW/SW (no request is issued)
//   mw_*                   registered M/W outputs consumed by writeback
module mem_stage #(
    parameter logic [1:0] WORD_SIZE = 2'b00,
    parameter logic [1:0] BYTE_SIZE = 2'b11
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [31:0] insn_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_in,
    input  logic        rwe_in,
    input  logic [31:0] wb_data,
    input  logic [4:0]  wb_rd,
    input  logic        wb_rwe,
    mem_stage_if.master dm,
    output logic        stall_out,
    output logic        misaligned,
    output logic        mw_valid,
    output logic [31:0] mw_insn,
    output logic [31:0] mw_o,
    output logic [31:0] mw_d,
    output logic [4:0]  mw_rd,
    output logic        mw_rwe
);
    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpLb  = 6'b100000;
    localparam logic [5:0] OpLbu = 6'b100100;
    localparam logic [5:0] OpSw  = 6'b101011;
    localparam logic [5:0] OpSb  = 6'b101000;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d, insn_q, insn_d, sdata_q, sdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        rwe_q, rwe_d;

    logic        mw_valid_d, mw_rwe_d;
    logic [31:0] mw_insn_d, mw_o_d, mw_d_d;
    logic [4:0]  mw_rd_d;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OpLw) || (op == OpLb) || (op == OpLbu);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OpSw) || (op == OpSb);
    endfunction

    function automatic logic is_byte(input logic [5:0] op);
        return (op == OpLb) || (op == OpLbu) || (op == OpSb);
    endfunction

    function automatic logic [31:0] load_ext(input logic [5:0] op, input logic [31:0] data);
        case (op)
            OpLw:    return data;
            OpLb:    return {{24{data[7]}}, data[7:0]};
            OpLbu:   return {24'h0, data[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    logic [5:0]  op_in, op_q;
    logic        mem_op_in, misal_in, bypass;
    logic [31:0] store_src, sdata_in;

    assign op_in     = insn_in[31:26];
    assign op_q      = insn_q[31:26];
    assign mem_op_in = valid_in & (is_load(op_in) | is_store(op_in));
    assign misal_in  = mem_op_in & ((op_in == OpLw) | (op_in == OpSw)) & (addr_in[1:0] != 2'b00);
    // Bypass keys on the store's rt field, not rd_in.
    assign bypass    = wb_rwe & (wb_rd != 5'd0) & (wb_rd == insn_in[20:16]);
    assign store_src = bypass ? wb_data : store_data_in;
    assign sdata_in  = is_byte(op_in) ? {24'h0, store_src[7:0]} : store_src;

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        insn_d            = insn_q;
        sdata_d           = sdata_q;
        rd_d              = rd_q;
        rwe_d             = rwe_q;
        dm.dm_enable      = 1'b0;
        dm.dm_address     = 32'h0;
        dm.dm_data_in     = 32'h0;
        dm.dm_access_size = WORD_SIZE;
        dm.dm_rw          = 1'b1;
        stall_out         = 1'b0;
        misaligned        = 1'b0;
        // Default is an M/W bubble; every completing path overwrites it.
        mw_valid_d        = 1'b0;
        mw_insn_d         = 32'h0;
        mw_o_d            = 32'h0;
        mw_d_d            = 32'h0;
        mw_rd_d           = 5'd0;
        mw_rwe_d          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!mem_op_in) begin
                    mw_valid_d = valid_in;
                    mw_insn_d  = insn_in;
                    mw_o_d     = addr_in;
                    mw_rd_d    = rd_in;
                    mw_rwe_d   = rwe_in & valid_in;
                end else if (misal_in) begin
                    misaligned = 1'b1;
                    mw_valid_d = 1'b1;
                    mw_insn_d  = insn_in;
                    mw_o_d     = addr_in;
                    mw_rd_d    = rd_in;
                end else begin
                    dm.dm_enable      = 1'b1;
                    dm.dm_address     = addr_in;
                    dm.dm_rw          = is_load(op_in);
                    dm.dm_access_size = is_byte(op_in) ? BYTE_SIZE : WORD_SIZE;
                    dm.dm_data_in     = is_store(op_in) ? sdata_in : 32'h0;
                    if (dm.dm_busy) begin
                        stall_out = 1'b1;
                        state_d   = StWait;
                        addr_d    = addr_in;
                        insn_d    = insn_in;
                        sdata_d   = sdata_in;
                        rd_d      = rd_in;
                        rwe_d     = rwe_in;
                    end else begin
                        mw_valid_d = 1'b1;
                        mw_insn_d  = insn_in;
                        mw_o_d     = addr_in;
                        mw_d_d     = load_ext(op_in, dm.dm_data_out);
                        mw_rd_d    = rd_in;
                        mw_rwe_d   = is_load(op_in) & rwe_in;
                    end
                end
            end
            StWait: begin
                dm.dm_enable      = 1'b1;
                dm.dm_address     = addr_q;
                dm.dm_rw          = is_load(op_q);
                dm.dm_access_size = is_byte(op_q) ? BYTE_SIZE : WORD_SIZE;
                dm.dm_data_in     = is_store(op_q) ? sdata_q : 32'h0;
                // Drop stall in the completing cycle so X/M advances on the same edge.
                stall_out         = dm.dm_busy;
                if (!dm.dm_busy) begin
                    state_d    = StIdle;
                    mw_valid_d = 1'b1;
                    mw_insn_d  = insn_q;
                    mw_o_d     = addr_q;
                    mw_d_d     = load_ext(op_q, dm.dm_data_out);
                    mw_rd_d    = rd_q;
                    mw_rwe_d   = is_load(op_q) & rwe_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs read as idle for the whole time reset is held, not just after the edge.
        if (!reset_n) begin
            dm.dm_enable      = 1'b0;
            dm.dm_address     = 32'h0;
            dm.dm_data_in     = 32'h0;
            dm.dm_access_size = WORD_SIZE;
            dm.dm_rw          = 1'b1;
            stall_out         = 1'b0;
            misaligned        = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            addr_q   <= 32'h0;
            insn_q   <= 32'h0;
            sdata_q  <= 32'h0;
            rd_q     <= 5'd0;
            rwe_q    <= 1'b0;
            mw_valid <= 1'b0;
            mw_insn  <= 32'h0;
            mw_o     <= 32'h0;
            mw_d     <= 32'h0;
            mw_rd    <= 5'd0;
            mw_rwe   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            insn_q   <= insn_d;
            sdata_q  <= sdata_d;
            rd_q     <= rd_d;
            rwe_q    <= rwe_d;
            mw_valid <= mw_valid_d;
            mw_insn  <= mw_insn_d;
            mw_o     <= mw_o_d;
            mw_d     <= mw_d_d;
            mw_rd    <= mw_rd_d;
            mw_rwe   <= mw_rwe_d;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. A transaction-level model predicts the
// handshake and M/W contents; a compare process checks them every cycle, and the
// directed sequence pins the model with hand-computed literals.
module tb_mem_stage;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        valid_in;
    logic [31:0] insn_in, addr_in, store_data_in;
    logic [4:0]  rd_in;
    logic        rwe_in;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_rwe;
    logic        stall_out, misaligned;
    logic        mw_valid, mw_rwe;
    logic [31:0] mw_insn, mw_o, mw_d;
    logic [4:0]  mw_rd;

    mem_stage_if dm_bus ();

    always #5 clock = ~clock;

    mem_stage #(.WORD_SIZE(2'b00), .BYTE_SIZE(2'b11)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .valid_in     (valid_in),
        .insn_in      (insn_in),
        .addr_in      (addr_in),
        .store_data_in(store_data_in),
        .rd_in        (rd_in),
        .rwe_in       (rwe_in),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_rwe       (wb_rwe),
        .dm           (dm_bus),
        .stall_out    (stall_out),
        .misaligned   (misaligned),
        .mw_valid     (mw_valid),
        .mw_insn      (mw_insn),
        .mw_o         (mw_o),
        .mw_d         (mw_d),
        .mw_rd        (mw_rd),
        .mw_rwe       (mw_rwe)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        v;
        logic [31:0] insn;
        logic [31:0] o;
        logic [31:0] d;
        logic [4:0]  rd;
        logic        rwe;
    } mw_t;

    function automatic bit f_load(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b100000 || op == 6'b100100;
    endfunction
    function automatic bit f_store(input logic [5:0] op);
        return op == 6'b101011 || op == 6'b101000;
    endfunction
    function automatic bit f_byte(input logic [5:0] op);
        return op == 6'b100000 || op == 6'b100100 || op == 6'b101000;
    endfunction
    function automatic bit f_misal(input logic [5:0] op, input logic [31:0] a);
        return (op == 6'b100011 || op == 6'b101011) && a[1:0] != 2'b00;
    endfunction
    function automatic logic [31:0] f_ext(input logic [5:0] op, input logic [31:0] x);
        if (op == 6'b100011) return x;
        if (op == 6'b100000) return {{24{x[7]}}, x[7:0]};
        if (op == 6'b100100) return {24'h0, x[7:0]};
        return 32'h0;
    endfunction
    function automatic logic [31:0] f_sdata(input logic [31:0] insn, input logic [31:0] sd,
                                            input logic [31:0] wd, input logic [4:0] wr,
                                            input logic ww);
        logic [31:0] src;
        src = (ww && wr != 5'd0 && wr == insn[20:16]) ? wd : sd;
        return f_byte(insn[31:26]) ? {24'h0, src[7:0]} : src;
    endfunction
    function automatic mw_t f_done(input logic [31:0] insn, input logic [31:0] a,
                                   input logic [4:0] rd, input logic rwe, input logic [31:0] x);
        mw_t r;
        r.v    = 1'b1;
        r.insn = insn;
        r.o    = a;
        r.d    = f_ext(insn[31:26], x);
        r.rd   = rd;
        r.rwe  = f_load(insn[31:26]) & rwe;
        return r;
    endfunction

    bit          m_pend;
    logic [31:0] p_insn, p_addr, p_sdata;
    logic [4:0]  p_rd;
    logic        p_rwe;
    bit          e_bubble;
    mw_t         e_mw;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_pend   <= 1'b0;
            e_bubble <= 1'b0;
            e_mw     <= '0;
        end else if (m_pend) begin
            if (dm_bus.dm_busy) begin
                e_bubble <= 1'b1;
            end else begin
                e_bubble <= 1'b0;
                e_mw     <= f_done(p_insn, p_addr, p_rd, p_rwe, dm_bus.dm_data_out);
                m_pend   <= 1'b0;
            end
        end else if (valid_in && (f_load(insn_in[31:26]) || f_store(insn_in[31:26]))) begin
            if (f_misal(insn_in[31:26], addr_in)) begin
                e_bubble <= 1'b0;
                e_mw     <= '{1'b1, insn_in, addr_in, 32'h0, rd_in, 1'b0};
            end else if (dm_bus.dm_busy) begin
                e_bubble <= 1'b1;
                m_pend   <= 1'b1;
                p_insn   <= insn_in;
                p_addr   <= addr_in;
                p_rd     <= rd_in;
                p_rwe    <= rwe_in;
                p_sdata  <= f_sdata(insn_in, store_data_in, wb_data, wb_rd, wb_rwe);
            end else begin
                e_bubble <= 1'b0;
                e_mw     <= f_done(insn_in, addr_in, rd_in, rwe_in, dm_bus.dm_data_out);
            end
        end else begin
            e_bubble <= 1'b0;
            e_mw     <= '{valid_in, insn_in, addr_in, 32'h0, rd_in, rwe_in & valid_in};
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] c_insn, c_addr, c_sdata;
    bit          c_en, c_stall, c_mis, c_mem;

    always @(negedge clock) begin
        if (!reset_n) begin
            check("reset_outputs",
                  {dm_bus.dm_address, dm_bus.dm_data_in, dm_bus.dm_access_size, dm_bus.dm_rw,
                   dm_bus.dm_enable, stall_out, misaligned},
                  {32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0});
        end else begin
            if (m_pend) begin
                c_insn  = p_insn;
                c_addr  = p_addr;
                c_sdata = p_sdata;
                c_en    = 1'b1;
                c_mis   = 1'b0;
            end else begin
                c_insn  = insn_in;
                c_addr  = addr_in;
                c_sdata = f_sdata(insn_in, store_data_in, wb_data, wb_rd, wb_rwe);
                c_mem   = valid_in && (f_load(insn_in[31:26]) || f_store(insn_in[31:26]));
                c_mis   = c_mem && f_misal(insn_in[31:26], addr_in);
                c_en    = c_mem && !c_mis;
            end
            c_stall = c_en && dm_bus.dm_busy;
            check("handshake", {dm_bus.dm_enable, stall_out, misaligned}, {c_en, c_stall, c_mis});
            if (c_en) begin
                check("request", {dm_bus.dm_address, dm_bus.dm_access_size, dm_bus.dm_rw},
                      {c_addr, f_byte(c_insn[31:26]) ? 2'b11 : 2'b00, f_load(c_insn[31:26])});
                if (f_store(c_insn[31:26]))
                    check("store_data", dm_bus.dm_data_in, c_sdata);
            end
        end
        if (e_bubble)
            check("mw_bubble", {mw_valid, mw_rwe}, 2'b00);
        else
            check("mw", {mw_valid, mw_insn, mw_o, mw_d, mw_rd, mw_rwe}, e_mw);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] a,
                         input logic [4:0] rd, input logic rwe);
        valid_in = v;
        insn_in  = insn;
        addr_in  = a;
        rd_in    = rd;
        rwe_in   = rwe;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        reset_n              = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        store_data_in        = 32'h0;
        wb_data              = 32'h0;
        wb_rd                = 5'd0;
        wb_rwe               = 1'b0;
        dm_bus.dm_busy       = 1'b0;
        dm_bus.dm_data_out   = 32'h0;
        step();
        step();
        check("rst_mw_valid", mw_valid, 1'b0);
        check("rst_dm_rw", dm_bus.dm_rw, 1'b1);
        reset_n = 1'b1;

        // ADD: 1-cycle pass-through
        drive(1'b1, 32'h0022_1820, 32'h15, 5'd3, 1'b1);
        #1 check("add_no_enable", {dm_bus.dm_enable, stall_out}, 2'b00);
        step();
        check("add_mw", {mw_valid, mw_o, mw_rd, mw_rwe}, {1'b1, 32'h15, 5'd3, 1'b1});

        // LW with three busy cycles
        drive(1'b1, {6'b100011, 5'd1, 5'd4, 16'h0010}, 32'h8002_0010, 5'd4, 1'b1);
        dm_bus.dm_busy     = 1'b1;
        dm_bus.dm_data_out = 32'hCAFE_BABE;
        #1 check("lw_req", {stall_out, dm_bus.dm_enable, dm_bus.dm_address},
                 {1'b1, 1'b1, 32'h8002_0010});
        step();
        check("lw_bubble1", {mw_valid, mw_rwe, stall_out}, 3'b001);
        step();
        check("lw_bubble2", {mw_valid, mw_rwe}, 2'b00);
        step();
        check("lw_bubble3", {mw_valid, mw_rwe}, 2'b00);
        dm_bus.dm_busy = 1'b0;
        #1 check("lw_done_cycle", {stall_out, dm_bus.dm_enable}, 2'b01);
        step();
        check("lw_mw", {mw_valid, mw_d, mw_rwe}, {1'b1, 32'hCAFE_BABE, 1'b1});

        // LB / LBU sign and zero extension
        dm_bus.dm_data_out = 32'h1234_5680;
        drive(1'b1, {6'b100000, 5'd1, 5'd5, 16'h0013}, 32'h8002_0013, 5'd5, 1'b1);
        #1 check("lb_size", dm_bus.dm_access_size, 2'b11);
        step();
        check("lb_mw_d", mw_d, 32'hFFFF_FF80);
        drive(1'b1, {6'b100100, 5'd1, 5'd6, 16'h0013}, 32'h8002_0013, 5'd6, 1'b1);
        step();
        check("lbu_mw_d", mw_d, 32'h0000_0080);

        // SW with and without W->M bypass
        drive(1'b1, {6'b101011, 5'd2, 5'd5, 16'h0}, 32'h100, 5'd0, 1'b0);
        store_data_in = 32'h11;
        wb_rwe        = 1'b1;
        wb_rd         = 5'd5;
        wb_data       = 32'h22;
        #1 check("sw_bypass", {dm_bus.dm_data_in, dm_bus.dm_rw}, {32'h22, 1'b0});
        wb_rd = 5'd6;
        #1 check("sw_no_bypass", dm_bus.dm_data_in, 32'h11);
        step();
        check("sw_mw", {mw_valid, mw_rwe, mw_d}, {1'b1, 1'b0, 32'h0});

        // SB drives the low byte only; rt = 0 never bypasses
        drive(1'b1, {6'b101000, 5'd2, 5'd7, 16'h3}, 32'h103, 5'd0, 1'b0);
        store_data_in = 32'h1234_56AB;
        #1 check("sb_data", {dm_bus.dm_data_in, dm_bus.dm_access_size}, {32'hAB, 2'b11});
        step();
        drive(1'b1, {6'b101011, 5'd2, 5'd0, 16'h0}, 32'h104, 5'd0, 1'b0);
        store_data_in = 32'h33;
        wb_rd         = 5'd0;
        #1 check("sw_r0_no_bypass", dm_bus.dm_data_in, 32'h33);
        step();
        wb_rwe = 1'b0;

        // Bubble carrying a load opcode
        drive(1'b0, {6'b100011, 5'd1, 5'd4, 16'h0}, 32'h40, 5'd4, 1'b1);
        #1 check("bubble_no_req", dm_bus.dm_enable, 1'b0);
        step();
        check("bubble_mw", {mw_valid, mw_rwe}, 2'b00);

        // Misaligned LW
        drive(1'b1, {6'b100011, 5'd1, 5'd8, 16'h2}, 32'h8002_0002, 5'd8, 1'b1);
        #1 check("mis_pulse", {misaligned, dm_bus.dm_enable, stall_out}, 3'b100);
        step();
        check("mis_mw", {mw_valid, mw_rwe, mw_d}, {1'b1, 1'b0, 32'h0});

        // Reset while waiting on a busy memory
        drive(1'b1, {6'b100011, 5'd1, 5'd4, 16'h0200}, 32'h200, 5'd4, 1'b1);
        dm_bus.dm_busy = 1'b1;
        step();
        step();
        reset_n = 1'b0;
        #1 check("rst_in_wait", {dm_bus.dm_enable, stall_out, dm_bus.dm_rw, mw_valid},
                 4'b0010);
        step();
        reset_n = 1'b1;
        drive(1'b1, 32'h0022_1820, 32'h44, 5'd9, 1'b1);
        #1 check("post_rst_no_stall", {stall_out, dm_bus.dm_enable}, 2'b00);
        step();
        check("post_rst_add", {mw_valid, mw_o, mw_rd, mw_rwe}, {1'b1, 32'h44, 5'd9, 1'b1});

        dm_bus.dm_busy = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
